// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the R-type CPU front end:
//   - fetch FSM state encoding (IDLE / REQ / HOLD)
//   - instruction field bit positions inside a 32-bit word
//   - default PC increment for sequential fetch
// Imported by the fetch unit, its field splitter and the decoder bench.
// ---------------------------------------------------------------------------
package cpu_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int SH_HI = 10;
  localparam int SH_LO = 6;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  localparam int PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the two handshakes of the fetch stage:
//   imem side : imem_req/imem_addr out, imem_ack/imem_rdata in
//   decode side: out_valid/out_pc/op/rs/rt/rd/shamt/funct out, out_ready in
// Modports:
//   master - the fetch unit
//   slave  - the environment (instruction memory + decoder)
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [5:0]        op;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output out_valid, out_pc, op, rs, rt, rd, shamt, funct,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  out_valid, out_pc, op, rs, rt, rd, shamt, funct,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch_unit_field_split.sv
// ---------------------------------------------------------------------------
// if_field_split
// Purely combinational split of an R-type instruction word into its fields.
// Ports:
//   ir     in  32  instruction word
//   op     out 6   ir[31:26]
//   rs     out 5   ir[25:21]
//   rt     out 5   ir[20:16]
//   rd     out 5   ir[15:11]
//   shamt  out 5   ir[10:6]
//   funct  out 6   ir[5:0]
// ---------------------------------------------------------------------------
module if_field_split
  import cpu_defs::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct
);
  assign op    = ir[OP_HI:OP_LO];
  assign rs    = ir[RS_HI:RS_LO];
  assign rt    = ir[RT_HI:RT_LO];
  assign rd    = ir[RD_HI:RD_LO];
  assign shamt = ir[SH_HI:SH_LO];
  assign funct = ir[FN_HI:FN_LO];
endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: holds the PC, fetches one 32-bit word per request over a
// req/ack handshake, latches it into the instruction register and presents
// the decoded fields to the decoder over a valid/ready handshake.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run               1 = new requests may be issued
//   pc_load/pc_target redirect strobe and target address
//   bus (master)      imem req/addr/ack/rdata and decode valid/ready/pc/fields
//   fetch_cnt, stall_cnt  (only when IF_PERF_CNT_EN is defined)
//                     accepted instructions / cycles stalled by the decoder
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import cpu_defs::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int                PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  instr_fetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q;
  logic [ADDR_W-1:0] out_pc_q;
  logic              ir_load;
  // A redirect seen while a request is outstanding: the address on the bus
  // must stay put, so the target is parked here until the ack arrives.
  logic              pend_flush_q, pend_flush_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic              out_valid;
  logic              handshake;

  assign out_valid     = (state_q == ST_HOLD);
  assign handshake     = out_valid && bus.out_ready;
  assign bus.out_valid = out_valid;
  assign bus.imem_req  = (state_q == ST_REQ);
  assign bus.imem_addr = pc_q;
  assign bus.out_pc    = out_pc_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, otherwise a
    // path that skips it infers a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    ir_load       = 1'b0;
    pend_flush_d  = pend_flush_q;
    pend_target_d = pend_target_q;
    case (state_q)
      ST_IDLE: begin
        if (pc_load) pc_d = pc_target;
        if (run)     state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.imem_ack) begin
          pend_flush_d = 1'b0;
          if (pc_load) begin
            // Redirect on the ack cycle itself: drop the word, newest target wins.
            pc_d    = pc_target;
            state_d = run ? ST_REQ : ST_IDLE;
          end else if (pend_flush_q) begin
            pc_d    = pend_target_q;
            state_d = run ? ST_REQ : ST_IDLE;
          end else begin
            ir_load = 1'b1;
            pc_d    = pc_q + STEP;  // wraps modulo 2^ADDR_W
            state_d = ST_HOLD;
          end
        end else if (pc_load) begin
          pend_flush_d  = 1'b1;
          pend_target_d = pc_target;
        end
      end
      ST_HOLD: begin
        // A redirect without a handshake flushes the held instruction; with a
        // handshake the transfer completes and only the PC is redirected.
        if (pc_load) pc_d = pc_target;
        if (handshake || pc_load) state_d = run ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= PC_RESET;
      ir_q          <= '0;
      out_pc_q      <= '0;
      pend_flush_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_flush_q  <= pend_flush_d;
      pend_target_q <= pend_target_d;
      if (ir_load) begin
        ir_q     <= bus.imem_rdata;
        out_pc_q <= pc_q;
      end
    end
  end

  if_field_split u_field_split (
    .ir    (ir_q),
    .op    (bus.op),
    .rs    (bus.rs),
    .rt    (bus.rt),
    .rd    (bus.rd),
    .shamt (bus.shamt),
    .funct (bus.funct)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (handshake)                  fetch_cnt <= fetch_cnt + 32'd1;
      if (out_valid && !bus.out_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_target = '0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(32)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (32),
    .PC_RESET (32'h0),
    .PC_STEP  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .bus       (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Count decoder handshakes as seen at the clock edge.
  always @(posedge clk) begin
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) hs_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({name, " req seen"}, 64'(bus.imem_req), 64'd1);
  endtask

  // Memory answers one cycle after it sees the request.
  task automatic fetch_one(input logic [31:0] word, input logic [31:0] addr, input string name);
    wait_req(name);
    check({name, " addr"}, 64'(bus.imem_addr), 64'(addr));
    tick();
    check({name, " addr stable"}, 64'({bus.imem_req, bus.imem_addr}), {31'd0, 1'b1, addr});
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    check({name, " valid"}, 64'(bus.out_valid), 64'd1);
    check({name, " req low"}, 64'(bus.imem_req), 64'd0);
    check({name, " out_pc"}, 64'(bus.out_pc), 64'(addr));
  endtask

  task automatic accept(input string name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, " valid drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    vecs[0] = '{32'h012A4020, 32'h0000_0000, 6'd0,    5'd9,  5'd10, 5'd8,  5'd0,  6'h20};
    vecs[1] = '{32'hFFFFFFFF, 32'h0000_0004, 6'd63,   5'd31, 5'd31, 5'd31, 5'd31, 6'd63};
    vecs[2] = '{32'h8C220004, 32'h0000_0008, 6'h23,   5'd1,  5'd2,  5'd0,  5'd0,  6'd4};
    vecs[3] = '{32'h00031080, 32'h0000_000C, 6'd0,    5'd0,  5'd3,  5'd2,  5'd2,  6'd0};

    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.out_ready  = 1'b0;

    // Reset state, with run already high.
    run = 1'b1;
    tick();
    tick();
    check("reset imem_req", 64'(bus.imem_req), 64'd0);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset imem_addr", 64'(bus.imem_addr), 64'd0);
    check("reset out_pc", 64'(bus.out_pc), 64'd0);
    check("reset fields", 64'({bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct}), 64'd0);
    rst_n = 1'b1;

    // Sequential stream, decoder always ready.
    for (int i = 0; i < 4; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      fetch_one(vecs[i].word, vecs[i].addr, nm);
      check({nm, " op"},    64'(bus.op),    64'(vecs[i].op));
      check({nm, " rs"},    64'(bus.rs),    64'(vecs[i].rs));
      check({nm, " rt"},    64'(bus.rt),    64'(vecs[i].rt));
      check({nm, " rd"},    64'(bus.rd),    64'(vecs[i].rd));
      check({nm, " shamt"}, 64'(bus.shamt), 64'(vecs[i].shamt));
      check({nm, " funct"}, 64'(bus.funct), 64'(vecs[i].funct));
      accept(nm);
    end
    check("stream handshakes", 64'(hs_cnt), 64'd4);

    // Decoder stalls for 5 cycles while an instruction is held.
    fetch_one(32'h8C220004, 32'h10, "stall");
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d valid/req", i), 64'({bus.out_valid, bus.imem_req}), 64'd2);
      check($sformatf("stall%0d fields", i),
            64'({bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct}), 64'h8C220004);
    end
`ifdef IF_PERF_CNT_EN
    check("stall_cnt after stall", 64'(stall_cnt), 64'd5);
    check("fetch_cnt before accept", 64'(fetch_cnt), 64'd4);
`endif
    accept("stall");
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt after accept", 64'(fetch_cnt), 64'd5);
`endif
    check("stall handshakes", 64'(hs_cnt), 64'd5);

    // Redirect while a request is outstanding: ack is discarded.
    wait_req("redir");
    check("redir addr", 64'(bus.imem_addr), 64'h14);
    pc_load   = 1'b1;
    pc_target = 32'h40;
    tick();
    pc_load   = 1'b0;
    check("redir addr held", 64'({bus.imem_req, bus.imem_addr}), {31'd0, 1'b1, 32'h14});
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hFFFFFFFF;
    tick();
    bus.imem_ack   = 1'b0;
    check("redir ack discarded", 64'(bus.out_valid), 64'd0);
    check("redir new addr", 64'({bus.imem_req, bus.imem_addr}), {31'd0, 1'b1, 32'h40});
    fetch_one(32'h00031080, 32'h40, "target");

    // Redirect while holding: flush, then fetch across the address wrap.
    pc_load   = 1'b1;
    pc_target = 32'hFFFFFFFC;
    tick();
    pc_load   = 1'b0;
    check("flush valid", 64'(bus.out_valid), 64'd0);
    check("flush new addr", 64'({bus.imem_req, bus.imem_addr}), {31'd0, 1'b1, 32'hFFFFFFFC});
    check("flush no handshake", 64'(hs_cnt), 64'd5);
    fetch_one(32'h012A4020, 32'hFFFFFFFC, "wrap");
    accept("wrap");
    wait_req("after wrap");
    check("wrap next addr", 64'(bus.imem_addr), 64'h0);
    check("wrap handshakes", 64'(hs_cnt), 64'd6);
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt final", 64'(fetch_cnt), 64'd6);
    check("stall_cnt final", 64'(stall_cnt), 64'd6);
`endif

    // Reset during an outstanding request; a late ack must be ignored.
    run   = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst mid req imem_req", 64'(bus.imem_req), 64'd0);
    check("rst mid req valid", 64'(bus.out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h12345678;
    tick();
    bus.imem_ack   = 1'b0;
    check("stray ack valid", 64'(bus.out_valid), 64'd0);
    check("stray ack req", 64'(bus.imem_req), 64'd0);
    tick();
    check("stray ack valid later", 64'(bus.out_valid), 64'd0);
    check("post reset addr", 64'(bus.imem_addr), 64'd0);
    check("post reset fields", 64'({bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct}), 64'd0);
`ifdef IF_PERF_CNT_EN
    check("counters after reset", 64'({fetch_cnt, stall_cnt}), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
